// File: rtl/decoder3_8_seq_if.sv
// ---------------------------------------------------------------------------
// decoder3_8_seq_if
//   Valid/ready code channel that feeds the sequenced 3-to-8 decoder.
//
//   Signals:
//     in_valid  master -> slave  a code is presented this cycle
//     in_ready  slave  -> master the receiver can accept a code this cycle
//     in_code   master -> slave  3-bit binary code 0..7
//
//   Modports:
//     master : producer of codes (testbench / upstream block)
//     slave  : the decoder
// ---------------------------------------------------------------------------
interface decoder3_8_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;

  modport master (
    output in_valid,
    output in_code,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_code,
    output in_ready
  );
endinterface

// File: rtl/decoder3_8_seq.sv
// ---------------------------------------------------------------------------
// decoder3_8_seq
//   Sequenced 3-to-8 decoder. Codes arrive over a valid/ready channel into a
//   2-entry FIFO. Each code is turned into a one-hot 8-bit strobe that is
//   driven for HOLD_CYCLES cycles, followed by GAP_CYCLES cycles of all-zero
//   output and one IDLE cycle before the next code may launch.
//
//   Parameters:
//     HOLD_CYCLES  cycles each one-hot word is driven        (1..255)
//     GAP_CYCLES   cycles of y = 0 after each hold           (1..255)
//
//   Ports:
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset; flushes the FIFO
//     in_if       slave side of the code channel (in_valid/in_ready/in_code)
//     en          launch enable, sampled only when the FSM is IDLE
//     y           registered one-hot word, or 8'h00
//     y_valid     high while y carries a decoded word
//     busy        FSM not IDLE or FIFO non-empty
//     fifo_level  FIFO occupancy 0..2
// ---------------------------------------------------------------------------
module decoder3_8_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  decoder3_8_seq_if.slave        in_if,
  input  logic                   en,
  output logic [7:0]             y,
  output logic                   y_valid,
  output logic                   busy,
  output logic [1:0]             fifo_level
);

  // Counter reload values; the counter counts down to zero so a state lasts
  // exactly (load + 1) cycles.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // FIFO storage and control
  // -------------------------------------------------------------------------
  logic [2:0] fifo_mem [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] level_reg;

  logic       push;
  logic       pop;
  logic [2:0] head_code;
  logic [7:0] head_onehot;

  // FSM registers
  state_t     state_reg;
  logic [7:0] cnt_reg;
  logic [7:0] y_reg;
  logic       y_valid_reg;

  // Ready is purely occupancy based: a full FIFO refuses a push even when a
  // pop happens in the same cycle, so ready never depends on en or the FSM.
  assign in_if.in_ready = (level_reg != 2'd2);

  assign push = in_if.in_valid && in_if.in_ready;

  // A pop is exactly a launch: only IDLE with a queued code and en high.
  assign pop  = (state_reg == IDLE) && en && (level_reg != 2'd0);

  assign head_code = fifo_mem[rd_ptr_reg];

  // One-hot decode of the FIFO head, one comparator per output bit.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_decode
      assign head_onehot[gi] = (head_code == 3'(gi));
    end
  endgenerate

  // Storage needs no reset: entries are only read when level_reg says they
  // were written after the last reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= in_if.in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      level_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      // Simultaneous push and pop (only possible at level 1) leaves the
      // level unchanged; the pointers still advance, keeping order.
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 2'd1;
        2'b01:   level_reg <= level_reg - 2'd1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output sequencer: IDLE -> DRIVE (hold) -> GAP (zero) -> IDLE
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= 8'd0;
      y_reg       <= 8'h00;
      y_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          y_reg       <= 8'h00;
          y_valid_reg <= 1'b0;
          if (pop) begin
            y_reg       <= head_onehot;
            y_valid_reg <= 1'b1;
            cnt_reg     <= HOLD_LOAD;
            state_reg   <= DRIVE;
          end
        end

        DRIVE: begin
          // en is deliberately ignored here so a word is never truncated.
          if (cnt_reg != 8'd0) begin
            cnt_reg <= cnt_reg - 8'd1;
          end else begin
            y_reg       <= 8'h00;
            y_valid_reg <= 1'b0;
            cnt_reg     <= GAP_LOAD;
            state_reg   <= GAP;
          end
        end

        GAP: begin
          y_reg       <= 8'h00;
          y_valid_reg <= 1'b0;
          if (cnt_reg != 8'd0) begin
            cnt_reg <= cnt_reg - 8'd1;
          end else begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg   <= IDLE;
          cnt_reg     <= 8'd0;
          y_reg       <= 8'h00;
          y_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign y          = y_reg;
  assign y_valid    = y_valid_reg;
  assign fifo_level = level_reg;
  assign busy       = (state_reg != IDLE) || (level_reg != 2'd0);

endmodule

// File: tb/tb_decoder3_8_seq.sv
// ---------------------------------------------------------------------------
// tb_decoder3_8_seq
//   Directed scenarios followed by randomized traffic. Accepted codes are
//   queued in order; the monitor predicts, cycle by cycle, when a word must
//   launch (enough cycles since the previous launch, a code waiting, en high)
//   and which one-hot value, occupancy, ready and busy must appear.
// ---------------------------------------------------------------------------
module tb_decoder3_8_seq;

  localparam int HOLD   = 4;
  localparam int GAP    = 1;
  // Cycles after a launch until the FSM is back in IDLE.
  localparam int RECOV  = HOLD + GAP;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] y;
  logic       y_valid;
  logic       busy;
  logic [1:0] fifo_level;

  decoder3_8_seq_if bus ();

  decoder3_8_seq #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (bus),
    .en         (en),
    .y          (y),
    .y_valid    (y_valid),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s @%0t: timed out waiting for DUT", name, $time);
  endtask

  // -------------------------------------------------------------------------
  // Reference model + monitor (samples on the falling edge)
  // -------------------------------------------------------------------------
  int exp_q[$];
  int level_m     = 0;
  int since       = RECOV;
  int cur_code    = 0;
  bit launch_pred = 1'b0;
  bit push_pend   = 1'b0;
  int pend_code   = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      level_m     = 0;
      since       = RECOV;
      launch_pred = 1'b0;
      push_pend   = 1'b0;
      check("rst_y",          32'(y),            32'h0);
      check("rst_y_valid",    32'(y_valid),      32'h0);
      check("rst_fifo_level", 32'(fifo_level),   32'h0);
      check("rst_in_ready",   32'(bus.in_ready), 32'h1);
      check("rst_busy",       32'(busy),         32'h0);
    end else begin
      // Effects of the rising edge that just passed.
      if (push_pend) begin
        exp_q.push_back(pend_code);
        level_m++;
      end
      if (launch_pred) begin
        cur_code = exp_q.pop_front();
        level_m--;
        since = 0;
      end else if (since < RECOV) begin
        since++;
      end

      check("y_valid",    32'(y_valid),      32'(since < HOLD));
      check("y",          32'(y),            (since < HOLD) ? 32'(1 << cur_code) : 32'h0);
      check("busy",       32'(busy),         32'((since < RECOV) || (level_m != 0)));
      check("fifo_level", 32'(fifo_level),   32'(level_m));
      check("in_ready",   32'(bus.in_ready), 32'(level_m != 2));

      // Predictions for the next rising edge.
      launch_pred = (since >= RECOV) && (level_m > 0) && (en == 1'b1);
      push_pend   = (bus.in_valid == 1'b1) && (level_m != 2);
      pend_code   = int'(bus.in_code);
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // -------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int code);
    bit r;
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_code  = 3'(code);
    forever begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      guard++;
      if (guard > 60) begin
        timeout("push_accept");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (y_valid) break;
      guard++;
      if (guard > 60) begin
        timeout("wait_y_valid");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      guard++;
      if (guard > 200) begin
        timeout("wait_idle");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_code  = 3'd0;
    en           = 1'b1;
    rst_n        = 1'b1;
    #1;

    // Reset held for 3 cycles while a code is offered.
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd5;
    repeat (3) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    push(5);
    wait_idle();
    tick(3);

    // Single decode of code 3 with defaults.
    push(3);
    wait_idle();
    tick(2);

    // Stream all codes with in_valid effectively held high.
    for (int c = 0; c < 8; c++) push(c);
    wait_idle();
    tick(2);

    // Enable gating: fill the FIFO with en low, then release.
    en = 1'b0;
    push(6);
    push(1);
    tick(4);
    en = 1'b1;
    wait_idle();
    tick(2);

    // en dropped during the second DRIVE cycle of code 7; code 2 waits.
    push(7);
    push(2);
    wait_valid();
    en = 1'b0;
    tick(14);
    en = 1'b1;
    wait_idle();
    tick(2);

    // Asynchronous reset during DRIVE of code 4 with code 5 queued.
    push(4);
    push(5);
    wait_valid();
    rst_n = 1'b0;
    #1;
    check("async_rst_y",          32'(y),          32'h0);
    check("async_rst_y_valid",    32'(y_valid),    32'h0);
    check("async_rst_fifo_level", 32'(fifo_level), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(10);

    // Randomized traffic with occasional en drops and resets.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_code  = 3'($urandom_range(0, 7));
      en           = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end else begin
        tick(1);
      end
    end
    bus.in_valid = 1'b0;
    en           = 1'b1;
    wait_idle();
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
